// File: rtl/proc_pkg.sv
// ============================================================================
// Module : proc_pkg
// Brief  : Shared state, opcode and ALU-select definitions for the fetch/decode
//          controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package proc_pkg;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_e;

   localparam logic [3:0] OP_NOOP  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_LOAD  = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_HALT  = 4'b0101;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;

   // Unassigned opcodes fall back to NOOP so stray ROM words are harmless.
   function automatic state_e decode_op(input logic [3:0] opcode);
      case (opcode)
         OP_STORE: decode_op = S_STORE;
         OP_LOAD:  decode_op = S_LOAD_A;
         OP_ADD:   decode_op = S_ADD;
         OP_SUB:   decode_op = S_SUB;
         OP_HALT:  decode_op = S_HALT;
         default:  decode_op = S_NOOP;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_register.sv
// ============================================================================
// Module : instruction_register
// Brief  : 16-bit holding register with load enable and synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_register (
   input  logic        clk,
   input  logic        clr,
   input  logic        ld,
   input  logic [15:0] ir_in,
   output logic [15:0] ir_out
);

   logic [15:0] data_d;
   logic [15:0] data_q;

   always_comb begin
      data_d = data_q;
      if (ld) begin
         data_d = ir_in;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         data_q <= 16'h0000;
      end else begin
         data_q <= data_d;
      end
   end

   assign ir_out = data_q;

endmodule

`default_nettype wire

// File: rtl/fetch_decode_controller.sv
// ============================================================================
// Module : fetch_decode_controller
// Brief  : Multi-cycle fetch/decode/execute sequencer driving PC, data memory,
//          register file and ALU control strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_decode_controller (
   input  logic        clk,
   input  logic        clear,
   input  logic [15:0] rom_q,
   output logic        pc_up,
   output logic        pc_clr,
   output logic [7:0]  d_addr,
   output logic        d_wr,
   output logic [3:0]  rf_ra_addr,
   output logic [3:0]  rf_rb_addr,
   output logic [3:0]  rf_w_addr,
   output logic        rf_ra_rd,
   output logic        rf_rb_rd,
   output logic        rf_w_wr,
   output logic        rf_s,
   output logic [2:0]  alu_s0,
   output logic [3:0]  state_out,
   output logic        halted
);

   import proc_pkg::*;

   state_e      state_d;
   state_e      state_q;
   logic [15:0] ir_q;
   logic        ir_ld;

   assign ir_ld = (state_q == S_FETCH);

   instruction_register u_ir (
      .clk    (clk),
      .clr    (clear),
      .ld     (ir_ld),
      .ir_in  (rom_q),
      .ir_out (ir_q)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= S_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_INIT;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = decode_op(ir_q[15:12]);
         S_LOAD_A: state_d = S_LOAD_B;
         S_NOOP,
         S_LOAD_B,
         S_STORE,
         S_ADD,
         S_SUB:    state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   always_comb begin
      pc_up      = 1'b0;
      pc_clr     = 1'b0;
      d_addr     = 8'h00;
      d_wr       = 1'b0;
      rf_ra_addr = 4'h0;
      rf_rb_addr = 4'h0;
      rf_w_addr  = 4'h0;
      rf_ra_rd   = 1'b0;
      rf_rb_rd   = 1'b0;
      rf_w_wr    = 1'b0;
      rf_s       = 1'b0;
      alu_s0     = ALU_PASS;
      halted     = 1'b0;
      case (state_q)
         S_INIT:  pc_clr = 1'b1;
         S_FETCH: pc_up  = 1'b1;
         // Two-cycle load: LOAD_A presents the address, LOAD_B writes the RAM data back.
         S_LOAD_A, S_LOAD_B: begin
            d_addr    = ir_q[11:4];
            rf_w_addr = ir_q[3:0];
            rf_s      = 1'b1;
            rf_w_wr   = (state_q == S_LOAD_B);
         end
         S_STORE: begin
            rf_ra_addr = ir_q[11:8];
            rf_ra_rd   = 1'b1;
            d_addr     = ir_q[7:0];
            d_wr       = 1'b1;
         end
         S_ADD, S_SUB: begin
            rf_ra_addr = ir_q[11:8];
            rf_rb_addr = ir_q[7:4];
            rf_w_addr  = ir_q[3:0];
            rf_ra_rd   = 1'b1;
            rf_rb_rd   = 1'b1;
            rf_w_wr    = 1'b1;
            alu_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign state_out = state_q;

endmodule

`default_nettype wire

// File: doc/fetch_decode_controller.md
FETCH_DECODE_CONTROLLER -- requirements
Module: fetch_decode_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port rom_q, input, 16, the instruction word at the current program-counter address, combinationally valid in the FETCH cycle.
REQ-004 SHALL have port pc_up, output, 1, increment strobe to the program counter.
REQ-005 SHALL have port pc_clr, output, 1, clear strobe to the program counter.
REQ-006 SHALL have ports d_addr (output, 8) and d_wr (output, 1), the data-memory address and write enable.
REQ-007 SHALL have ports rf_ra_addr, rf_rb_addr, rf_w_addr (outputs, 4 each), the register-file read A, read B and write addresses.
REQ-008 SHALL have ports rf_ra_rd, rf_rb_rd, rf_w_wr (outputs, 1 each), the register-file read and write enables.
REQ-009 SHALL have port rf_s, output, 1, the write-back source: 1 = data memory, 0 = ALU.
REQ-010 SHALL have port alu_s0, output, 3, the ALU function: 0 = pass, 1 = add, 2 = sub.
REQ-011 SHALL have ports state_out (output, 4), the current state encoding, and halted (output, 1).

Function
REQ-012 SHALL hold a 16-bit instruction register (IR) loaded from rom_q only in FETCH.
REQ-013 SHALL implement states INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
REQ-014 SHALL use opcode IR[15:12] with these encodings:
- 0000 NOOP
- 0001 STORE
- 0010 LOAD
- 0011 ADD
- 0100 SUB
- 0101 HALT
- any other value decodes to NOOP.
REQ-015 SHALL follow these transitions:
- INIT->FETCH
- FETCH->DECODE
- DECODE->opcode state (LOAD goes to LOAD_A)
- LOAD_A->LOAD_B
- NOOP, LOAD_B, STORE, ADD, SUB->FETCH
- HALT->HALT.
REQ-016 SHALL decode outputs combinationally from state and IR; every output not listed for a state is 0.
REQ-017 INIT SHALL assert pc_clr=1.
REQ-018 FETCH SHALL assert pc_up=1, with the IR load and the PC increment taking effect on the same edge.
REQ-019 LOAD_A SHALL drive d_addr=IR[11:4], rf_w_addr=IR[3:0], rf_s=1; LOAD_B SHALL hold those values and add rf_w_wr=1, covering the 1-cycle RAM read latency.
REQ-020 STORE SHALL drive rf_ra_addr=IR[11:8], rf_ra_rd=1, d_addr=IR[7:0], d_wr=1.
REQ-021 ADD and SUB SHALL drive rf_ra_addr=IR[11:8], rf_rb_addr=IR[7:4], rf_w_addr=IR[3:0], rf_ra_rd=rf_rb_rd=rf_w_wr=1, rf_s=0, with alu_s0=1 for ADD and alu_s0=2 for SUB.
REQ-022 HALT SHALL assert halted=1, and pc_up SHALL never be asserted while in HALT.
REQ-023 Latency SHALL be 3 cycles per instruction for NOOP/STORE/ADD/SUB and 4 cycles for LOAD, measured FETCH to FETCH.
REQ-024 Every write strobe (d_wr, rf_w_wr) SHALL be asserted for exactly one cycle per instruction.
REQ-025 pc_up and pc_clr SHALL never be asserted in the same cycle.

Reset
REQ-026 clear=1 at any edge, in any state including mid-LOAD and HALT, SHALL force state=INIT and IR=16'h0000 on that edge.
REQ-027 The cycle after reset SHALL show state INIT with pc_clr=1, halted=0, and all other outputs 0.
REQ-028 A write strobe from the interrupted instruction SHALL NOT be issued after clear.

Structure
REQ-029 Shared package proc_pkg SHALL hold:
- the state enum (4-bit)
- opcode localparams
- ALU select constants (ALU_PASS=0, ALU_ADD=1, ALU_SUB=2).
REQ-030 SHALL instantiate one sub-module, instruction_register (16-bit, ld and synchronous clear), inside the controller.

Verification
REQ-031 Reset: clear=1 for 2 cycles, then 0 -> INIT with pc_clr=1; next cycle FETCH with pc_up=1; next cycle DECODE.
REQ-032 ADD: rom_q=16'h3215 in FETCH -> ADD state with rf_ra_addr=2, rf_rb_addr=1, rf_w_addr=5, alu_s0=1, rf_w_wr=1 for one cycle; FETCH again 3 cycles after the first FETCH.
REQ-033 LOAD: rom_q=16'h2A73 -> LOAD_A then LOAD_B with d_addr=8'hA7 and rf_w_addr=3; rf_s=1 in both; rf_w_wr=1 only in LOAD_B; 4-cycle loop.
REQ-034 STORE and illegal opcode:
- 16'h14C8 -> rf_ra_addr=4, d_addr=8'hC8, d_wr=1 for one cycle
- 16'hF123 -> NOOP with all strobes 0.
REQ-035 HALT: 16'h5000 -> halted=1 held for 20+ cycles with pc_up=0 throughout; clear=1 -> INIT, halted=0.
REQ-036 Mid-operation reset: clear=1 during LOAD_A -> next state INIT with no rf_w_wr pulse, and pc_clr=1.
